reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter: GAP_CYCLES, default 0, idle cycles inserted between consecutive entries (0..255).
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: resetN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a dump; sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  cancel a dump in progress.
REQ-006 SHALL have port: firstReg  input  5  first register index; sampled with start.
REQ-007 SHALL have port: lastReg  input  5  last register index; sampled with start.
REQ-008 SHALL have port: regAddr  output  5  read-port address to the register file.
REQ-009 SHALL have port: regData  input  32  combinational read-port data for regAddr.
REQ-010 SHALL have port: outValid  output  1  entry available.
REQ-011 SHALL have port: outReady  input  1  consumer accepts the entry.
REQ-012 SHALL have port: outIndex  output  5  register index of the current entry.
REQ-013 SHALL have port: outData  output  32  captured register value.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, HOLD, GAP, DONE.
REQ-017 In IDLE with start=1, SHALL latch firstReg/lastReg, set index=firstReg, and go to ADDR.
REQ-018 In ADDR, SHALL drive regAddr=index, capture regData into outData and index into outIndex at the next posedge, and go to HOLD.
REQ-019 In HOLD, SHALL hold outValid=1 with outData and outIndex stable until outValid&&outReady.
REQ-020 On HOLD handshake with index==lastReg, SHALL go to DONE; otherwise index SHALL increment modulo 32 (31 wraps to 0).
REQ-021 After a non-final handshake, SHALL go to GAP when GAP_CYCLES>0 (stay exactly GAP_CYCLES cycles, then go to ADDR), or directly to ADDR when GAP_CYCLES==0.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-023 When lastReg<firstReg, SHALL dump by wrap-around: firstReg..31, then 0..lastReg.
REQ-024 When firstReg==lastReg, SHALL dump exactly one entry.
REQ-025 Latency: start to first outValid SHALL be 2 cycles.
REQ-026 SHALL ignore start while busy=1.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, drop outValid, and produce no done pulse; abort SHALL take priority over a same-cycle handshake.
REQ-028 regAddr SHALL be 0 in IDLE, and entry 0 SHALL read as 0.
REQ-029 Register-file writes occur on negedge; the value sampled SHALL be the one present at the ADDR posedge.

Reset
REQ-030 resetN=0 SHALL force IDLE asynchronously, with outValid=0, busy=0, done=0, regAddr=0, outIndex=0, outData=0, gap counter 0, and checksum 0.
REQ-031 Reset mid-dump SHALL discard the dump; after release, SHALL wait for a new start.

Configuration
REQ-032 With REG_DUMP_CHECKSUM_EN defined, SHALL add output checksum[31:0]: the modulo-2^32 sum of all accepted outData in the current dump, cleared on start, valid when done=1, and held until the next start.
REQ-033 Without REG_DUMP_CHECKSUM_EN, the checksum port and logic SHALL be absent, with all other behaviour identical.

Structure
REQ-034 The FSM state typedef, REG_IDX_W=5, and DATA_W=32 SHALL live in shared package cpu_pkg.
REQ-035 The gap counter SHALL be sub-module dump_gap_counter (load, decrement, zero flag); everything else SHALL be flat.

Verification
REQ-036 Preload r1..r3=0x11,0x22,0x33; start with first=1, last=3, outReady=1 -> entries (1,0x11),(2,0x22),(3,0x33), then done, with first outValid 2 cycles after start.
REQ-037 Start with first=30, last=1 -> indices 30,31,0,1 in order, with index 0 data 0.
REQ-038 Hold outReady=0 for 5 cycles on entry 2 -> outValid, outIndex, and outData stable for all 5 cycles; no skipped entries.
REQ-039 Assert abort during HOLD of entry 2 together with outReady=1 -> IDLE next cycle, no done, and start during the dump ignored.
REQ-040 With GAP_CYCLES=3 -> exactly 3 outValid=0 cycles between handshakes; resetN low mid-dump -> all outputs 0 immediately.
REQ-041 With REG_DUMP_CHECKSUM_EN, dumping r1..r3 above -> checksum=0x66 at done.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-dump engine.
//   REG_IDX_W    : register index width (32 architectural registers)
//   DATA_W       : register data width
//   GAP_W        : width of the inter-entry gap counter (GAP_CYCLES 0..255)
//   dump_state_t : dump FSM state encoding
//   next_idx()   : register index successor, wrapping 31 -> 0
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int GAP_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD,
        GAP,
        DONE
    } dump_state_t;

    // The index width makes the increment wrap naturally from 31 to 0.
    function automatic logic [REG_IDX_W-1:0] next_idx(input logic [REG_IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/dump_gap_counter.sv
// Idle-gap down-counter for the register-dump engine.
// Ports:
//   clock      : clock, state updates on posedge
//   resetN     : asynchronous active-low reset (count cleared)
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one (saturates at zero)
//   zero       : count is zero
module dump_gap_counter
    import cpu_pkg::*;
(
    input  logic             clock,
    input  logic             resetN,
    input  logic             load,
    input  logic [GAP_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [GAP_W-1:0] count_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/reg_dump.sv
// Register-file dump engine: walks register indices firstReg..lastReg
// (wrapping past 31), reads each through a combinational read port and
// presents (index, value) entries on a valid/ready stream.
// Ports:
//   clock, resetN       : clock (posedge) and asynchronous active-low reset
//   start, abort        : begin a dump (IDLE only) / cancel a dump in progress
//   firstReg, lastReg   : index range, sampled with start
//   regAddr, regData    : register-file read port (regAddr is 0 while idle)
//   outValid, outReady  : entry handshake
//   outIndex, outData   : current entry
//   busy, done          : not idle / one-cycle completion pulse
//   checksum            : only with REG_DUMP_CHECKSUM_EN defined; modulo-2^32
//                         sum of accepted entries of the current dump
// Parameter GAP_CYCLES : idle cycles between consecutive entries (0..255).
module reg_dump
    import cpu_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 start,
    input  logic                 abort,
    input  logic [REG_IDX_W-1:0] firstReg,
    input  logic [REG_IDX_W-1:0] lastReg,
    output logic [REG_IDX_W-1:0] regAddr,
    input  logic [DATA_W-1:0]    regData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [REG_IDX_W-1:0] outIndex,
    output logic [DATA_W-1:0]    outData,
    output logic                 busy,
    output logic                 done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]    checksum
`endif
);

    localparam bit             GAP_EN   = (GAP_CYCLES > 0);
    // The GAP state is left when the counter reads zero, so loading N-1
    // yields exactly N cycles in GAP.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_EN ? GAP_W'(GAP_CYCLES - 1) : '0;

    dump_state_t          state_reg, state_next;
    logic [REG_IDX_W-1:0] index_reg, last_reg, out_index_reg;
    logic [DATA_W-1:0]    out_data_reg;
    logic                 start_take, capture, advance;
    logic                 gap_load, gap_dec, gap_zero;

    dump_gap_counter u_gap (
        .clock      (clock),
        .resetN     (resetN),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (gap_dec),
        .zero       (gap_zero)
    );

    always_comb begin
        state_next = state_reg;
        start_take = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_take = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (outReady) begin
                    if (index_reg == last_reg) begin
                        state_next = DONE;
                    end else begin
                        advance = 1'b1;
                        if (GAP_EN) begin
                            gap_load   = 1'b1;
                            state_next = GAP;
                        end else begin
                            state_next = ADDR;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_next = ADDR;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle handshake.
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            capture    = 1'b0;
            advance    = 1'b0;
            gap_load   = 1'b0;
            gap_dec    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            last_reg      <= '0;
            out_index_reg <= '0;
            out_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start_take) begin
                index_reg <= firstReg;
                last_reg  <= lastReg;
            end else if (advance) begin
                index_reg <= next_idx(index_reg);
            end
            if (capture) begin
                out_index_reg <= index_reg;
                // Register 0 is hard-wired to zero regardless of the port data.
                out_data_reg  <= (index_reg == '0) ? '0 : regData;
            end
        end
    end

    assign regAddr  = (state_reg == IDLE) ? '0 : index_reg;
    assign outValid = (state_reg == HOLD);
    assign outIndex = out_index_reg;
    assign outData  = out_data_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE) && !abort;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            checksum_reg <= '0;
        end else if (start_take) begin
            checksum_reg <= '0;
        end else if ((state_reg == HOLD) && outReady && !abort) begin
            checksum_reg <= checksum_reg + out_data_reg;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: two instances (GAP_CYCLES=0 and GAP_CYCLES=3) share a
// behavioural register file; one is selected per dump. Expected entries are
// derived from the index range and the register file contents.
module tb_reg_dump;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start_drv;
    logic        sel;
    logic        abort;
    logic [4:0]  firstReg, lastReg;
    logic        outReady;
    logic [31:0] regs [32];
    bit          scribble;

    logic [4:0]  regAddr_a, outIndex_a, regAddr_b, outIndex_b;
    logic [31:0] regData_a, outData_a, regData_b, outData_b;
    logic        outValid_a, busy_a, done_a, outValid_b, busy_b, done_b;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] checksum_a, checksum_b;
`endif

    int total = 0;
    int bad   = 0;

    assign regData_a = regs[regAddr_a];
    assign regData_b = regs[regAddr_b];

    reg_dump #(.GAP_CYCLES(0)) dut_a (
        .clock    (clock),
        .resetN   (resetN),
        .start    (start_drv & ~sel),
        .abort    (abort),
        .firstReg (firstReg),
        .lastReg  (lastReg),
        .regAddr  (regAddr_a),
        .regData  (regData_a),
        .outValid (outValid_a),
        .outReady (outReady),
        .outIndex (outIndex_a),
        .outData  (outData_a),
        .busy     (busy_a),
        .done     (done_a)
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        .checksum (checksum_a)
`endif
    );

    reg_dump #(.GAP_CYCLES(3)) dut_b (
        .clock    (clock),
        .resetN   (resetN),
        .start    (start_drv & sel),
        .abort    (abort),
        .firstReg (firstReg),
        .lastReg  (lastReg),
        .regAddr  (regAddr_b),
        .regData  (regData_b),
        .outValid (outValid_b),
        .outReady (outReady),
        .outIndex (outIndex_b),
        .outData  (outData_b),
        .busy     (busy_b),
        .done     (done_b)
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        .checksum (checksum_b)
`endif
    );

    // Outputs of the currently selected instance.
    logic        v, bz, dn;
    logic [4:0]  oi, ra;
    logic [31:0] od, cs;

    always_comb begin
        v  = sel ? outValid_b : outValid_a;
        bz = sel ? busy_b     : busy_a;
        dn = sel ? done_b     : done_a;
        oi = sel ? outIndex_b : outIndex_a;
        ra = sel ? regAddr_b  : regAddr_a;
        od = sel ? outData_b  : outData_a;
        cs = 32'd0;
`ifdef REG_DUMP_CHECKSUM_EN
        cs = sel ? checksum_b : checksum_a;
`endif
    end

    always #5 clock = ~clock;

    // Register-file writes happen on the falling edge only.
    always @(negedge clock) begin
        if (scribble && ($urandom_range(0, 3) == 0))
            regs[$urandom_range(1, 31)] = $urandom;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One dump on instance s. abort_k: entry position to abort on (-1 none).
    // stall_k/stall_n: hold outReady low for stall_n cycles on entry stall_k.
    task automatic do_dump(input bit s, input int first, input int last, input int pct,
                           input int abort_k, input int stall_k, input int stall_n,
                           input bit noise);
        int          n, g, lowcnt, waited, wait_cyc;
        logic [4:0]  idx;
        logic [31:0] exp_d, sum;
        bit          hs, rdy;
        g   = s ? 3 : 0;
        n   = ((last - first + 32) % 32) + 1;
        sum = 32'd0;
        sel = s; firstReg = 5'(first); lastReg = 5'(last);
        start_drv = 1'b1; outReady = 1'b0; abort = 1'b0;
        tick();
        start_drv = 1'b0; firstReg = 5'($urandom); lastReg = 5'($urandom);
        check("addr_valid", 32'(v), 32'd0);
        check("addr_busy", 32'(bz), 32'd1);
        tick();
        check("latency", 32'(v), 32'd1);
        for (int k = 0; k < n; k++) begin
            idx = 5'((first + k) % 32);
            if (k > 0) begin
                // Gap between entries: GAP cycles plus the single ADDR cycle.
                lowcnt = 0; wait_cyc = 0;
                while (!v && wait_cyc < 20) begin
                    lowcnt++;
                    start_drv = noise && ($urandom_range(0, 3) == 0);
                    tick();
                    wait_cyc++;
                end
                start_drv = 1'b0;
                check("gap", 32'(lowcnt), 32'(g + 1));
            end
            if (!v) begin
                check("valid_timeout", 32'(v), 32'd1);
                return;
            end
            exp_d = (idx == 5'd0) ? 32'd0 : regs[idx];
            check("index", 32'(oi), 32'(idx));
            check("data", od, exp_d);
            waited = 0; hs = 1'b0;
            while (!hs && waited < 64) begin
                if (k == abort_k) begin
                    abort = 1'b1; outReady = 1'b1; start_drv = 1'b0;
                    tick();
                    abort = 1'b0; outReady = 1'b0;
                    check("abort_valid", 32'(v), 32'd0);
                    check("abort_busy", 32'(bz), 32'd0);
                    check("abort_done", 32'(dn), 32'd0);
                    repeat (3) begin
                        tick();
                        check("abort_quiet", 32'(dn | bz), 32'd0);
                    end
                    return;
                end
                rdy = (k == stall_k && waited < stall_n) ? 1'b0 : ($urandom_range(1, 100) <= pct);
                outReady  = rdy;
                start_drv = noise && ($urandom_range(0, 3) == 0);
                tick();
                waited++;
                if (rdy) begin
                    hs = 1'b1;
                end else begin
                    check("hold_valid", 32'(v), 32'd1);
                    check("hold_index", 32'(oi), 32'(idx));
                    check("hold_data", od, exp_d);
                end
            end
            outReady = 1'b0; start_drv = 1'b0;
            if (!hs) begin
                check("hs_timeout", 32'(hs), 32'd1);
                return;
            end
            sum += exp_d;
        end
        check("done", 32'(dn), 32'd1);
        check("done_busy", 32'(bz), 32'd1);
        check("done_valid", 32'(v), 32'd0);
`ifdef REG_DUMP_CHECKSUM_EN
        check("checksum", cs, sum);
`endif
        tick();
        check("done_pulse", 32'(dn), 32'd0);
        check("idle_busy", 32'(bz), 32'd0);
        check("idle_addr", 32'(ra), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(v), 32'd0);
        check({tag, "_busy"}, 32'(bz), 32'd0);
        check({tag, "_done"}, 32'(dn), 32'd0);
        check({tag, "_addr"}, 32'(ra), 32'd0);
        check({tag, "_index"}, 32'(oi), 32'd0);
        check({tag, "_data"}, od, 32'd0);
        check({tag, "_sum"}, cs, 32'd0);
    endtask

    initial begin
        int f, l, n, ab;
        resetN = 1'b0; start_drv = 1'b0; sel = 1'b0; abort = 1'b0;
        firstReg = 5'd0; lastReg = 5'd0; outReady = 1'b0; scribble = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hdead_beef;   // the engine must still report 0 for r0
        regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33;

        repeat (2) tick();
        sel = 1'b0; #1; check_zero("rst_a");
        sel = 1'b1; #1; check_zero("rst_b");
        tick();
        resetN = 1'b1;
        tick();

        // Basic dump r1..r3, wrap-around, single entries.
        do_dump(1'b0, 1, 3, 100, -1, -1, 0, 1'b0);
        do_dump(1'b0, 30, 1, 100, -1, -1, 0, 1'b0);
        do_dump(1'b0, 7, 7, 100, -1, -1, 0, 1'b0);
        do_dump(1'b1, 31, 31, 100, -1, -1, 0, 1'b0);
        // Backpressure on the entry for r2, then abort on r2 with start noise.
        do_dump(1'b0, 1, 4, 100, -1, 1, 5, 1'b0);
        do_dump(1'b0, 1, 5, 100, 1, -1, 0, 1'b1);
        // Gapped instance.
        do_dump(1'b1, 1, 3, 100, -1, -1, 0, 1'b0);
        do_dump(1'b1, 28, 2, 100, -1, 2, 5, 1'b1);

        // Randomised dumps while the register file keeps changing.
        scribble = 1'b1;
        for (int t = 0; t < 24; t++) begin
            f  = $urandom_range(0, 31);
            l  = $urandom_range(0, 31);
            n  = ((l - f + 32) % 32) + 1;
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            do_dump(t[0], f, l, 60, ab, -1, 0, 1'b1);
        end
        scribble = 1'b0;

        // Reset in the middle of a dump.
        sel = 1'b1; firstReg = 5'd4; lastReg = 5'd20; start_drv = 1'b1; outReady = 1'b0;
        tick();
        start_drv = 1'b0;
        tick();
        check("pre_rst_valid", 32'(v), 32'd1);
        #2 resetN = 1'b0;
        #1 check_zero("mid_rst");
        tick();
        resetN = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_idle", 32'(bz | v), 32'd0);
        end
        do_dump(1'b1, 2, 3, 100, -1, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
